// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hamming_pkg
// Description : Shared types and Hamming(7,4) helpers for the scrub reader.
// Revision    : 1.0 - initial release
// ============================================================================
package hamming_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Syndrome value that identifies each flippable bit of a 7-bit block
  localparam logic [2:0] c_syn_d0 = 3'b111;
  localparam logic [2:0] c_syn_d1 = 3'b011;
  localparam logic [2:0] c_syn_d2 = 3'b101;
  localparam logic [2:0] c_syn_d3 = 3'b110;
  localparam logic [2:0] c_syn_p0 = 3'b001;
  localparam logic [2:0] c_syn_p1 = 3'b010;
  localparam logic [2:0] c_syn_p2 = 3'b100;

  function automatic logic [2:0] hamming74_parity(input logic [3:0] d);
    return {d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3], d[0] ^ d[1] ^ d[2]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/hamming74_block_fix.sv
`default_nettype none
// ============================================================================
// Module      : hamming74_block_fix
// Description : Combinational single-error corrector for one 4+3 bit block.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming74_block_fix
  import hamming_pkg::*;
(
  input  logic [3:0] i_data,
  input  logic [2:0] i_parity,
  output logic [3:0] o_data,
  output logic [2:0] o_parity,
  output logic       o_corrected
);

  logic [2:0] w_syndrome;

  always_comb begin
    w_syndrome  = i_parity ^ hamming74_parity(i_data);
    o_data      = i_data;
    o_parity    = i_parity;
    o_corrected = |w_syndrome;
    case (w_syndrome)
      c_syn_d0: o_data[0]   = ~i_data[0];
      c_syn_d1: o_data[1]   = ~i_data[1];
      c_syn_d2: o_data[2]   = ~i_data[2];
      c_syn_d3: o_data[3]   = ~i_data[3];
      c_syn_p0: o_parity[0] = ~i_parity[0];
      c_syn_p1: o_parity[1] = ~i_parity[1];
      c_syn_p2: o_parity[2] = ~i_parity[2];
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hamming_scrub_reader.sv
`default_nettype none
// ============================================================================
// Module      : hamming_scrub_reader
// Description : Scrubs one Hamming(7,4)-protected word a block per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_scrub_reader
  import hamming_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int BLOCKS      = WIDTH / 4,
  parameter int PARITY_BITS = BLOCKS * 3,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIDTH-1:0]       data_in,
  input  logic [PARITY_BITS-1:0] parity_in,
  input  logic                   err_clr,
  output logic                   busy,
  output logic [WIDTH-1:0]       data_out,
  output logic [PARITY_BITS-1:0] parity_out,
  output logic                   wr_en,
  output logic                   done,
  output logic [BLOCKS-1:0]      corr_mask,
  output logic [CNT_W-1:0]       err_count
);

  localparam int IDX_W = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;

  generate
    if ((WIDTH % 4) != 0) begin : g_width_check
      $error("hamming_scrub_reader: WIDTH must be a multiple of 4");
    end
  endgenerate

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [WIDTH-1:0]       work_data_q, work_data_d;
  logic [PARITY_BITS-1:0] work_par_q, work_par_d;
  logic [BLOCKS-1:0]      corr_mask_q, corr_mask_d;
  logic [CNT_W-1:0]       err_count_q, err_count_d;
  logic [WIDTH-1:0]       data_out_q, data_out_d;
  logic [PARITY_BITS-1:0] parity_out_q, parity_out_d;
  logic                   wr_en_q, wr_en_d;
  logic                   done_q, done_d;

  logic [3:0] w_nib, w_fix_nib;
  logic [2:0] w_par, w_fix_par;
  logic       w_fix_corrected;

  assign w_nib = work_data_q[int'(idx_q)*4 +: 4];
  assign w_par = work_par_q[int'(idx_q)*3 +: 3];

  hamming74_block_fix u_fix (
    .i_data      (w_nib),
    .i_parity    (w_par),
    .o_data      (w_fix_nib),
    .o_parity    (w_fix_par),
    .o_corrected (w_fix_corrected)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    work_data_d  = work_data_q;
    work_par_d   = work_par_q;
    corr_mask_d  = corr_mask_q;
    err_count_d  = err_count_q;
    data_out_d   = data_out_q;
    parity_out_d = parity_out_q;
    wr_en_d      = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          work_data_d = data_in;
          work_par_d  = parity_in;
          corr_mask_d = '0;
          idx_d       = '0;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        work_data_d[int'(idx_q)*4 +: 4] = w_fix_nib;
        work_par_d[int'(idx_q)*3 +: 3]  = w_fix_par;
        if (w_fix_corrected) begin
          corr_mask_d[idx_q] = 1'b1;
          if (err_count_q != '1) begin
            err_count_d = err_count_q + CNT_W'(1);
          end
        end
        if (idx_q == IDX_W'(BLOCKS - 1)) begin
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      COMMIT: begin
        // Strobes are registered, so they appear in the cycle after COMMIT
        data_out_d   = work_data_q;
        parity_out_d = work_par_q;
        wr_en_d      = |corr_mask_q;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (err_clr) begin
      err_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      work_data_q  <= '0;
      work_par_q   <= '0;
      corr_mask_q  <= '0;
      err_count_q  <= '0;
      data_out_q   <= '0;
      parity_out_q <= '0;
      wr_en_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      work_data_q  <= work_data_d;
      work_par_q   <= work_par_d;
      corr_mask_q  <= corr_mask_d;
      err_count_q  <= err_count_d;
      data_out_q   <= data_out_d;
      parity_out_q <= parity_out_d;
      wr_en_q      <= wr_en_d;
      done_q       <= done_d;
    end
  end

  assign busy       = (state_q == CHECK) || (state_q == COMMIT);
  assign data_out   = data_out_q;
  assign parity_out = parity_out_q;
  assign wr_en      = wr_en_q;
  assign done       = done_q;
  assign corr_mask  = corr_mask_q;
  assign err_count  = err_count_q;

endmodule
`default_nettype wire

// File: doc/hamming_scrub_reader.md
Name: hamming_scrub_reader

Overview:
Reader/checker side for Hamming(7,4)-protected words held as width data bits plus 3 parity bits per 4-bit block. On start, it captures one stored word and parity vector, then checks one block per clock. It corrects any single-bit error in the data or parity bits and returns the repaired word through a one-cycle write-back strobe. It sits beside the protected counter store as its periodic scrubber and keeps a saturating count of corrected blocks.

Parameters:
width, 8, protected data width; must be a multiple of 4 (elaboration error otherwise)
blocks, width/4, number of 4-bit blocks
parity_bits, blocks*3, stored parity width
cnt_w, 8, width of the corrected-block counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request one scrub pass; sampled only in IDLE
data_in  in  width  stored data word
parity_in  in  parity_bits  stored parity vector
err_clr  in  1  synchronous clear of err_count
busy  out  1  high in CHECK and COMMIT
data_out  out  width  corrected data; valid while wr_en=1
parity_out  out  parity_bits  corrected parity; valid while wr_en=1
wr_en  out  1  one-cycle write-back strobe
done  out  1  one-cycle end-of-pass pulse
corr_mask  out  blocks  bit i set if block i was corrected in the last pass
err_count  out  cnt_w  saturating count of corrected blocks

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, wr_en, done = 0; data_out, parity_out, corr_mask, err_count = 0; block index = 0.
- Encoding per block i, with d_k = data[i*4+k]:
  - p[i*3+2] = d0^d2^d3
  - p[i*3+1] = d0^d1^d3
  - p[i*3+0] = d0^d1^d2
- Syndrome s[2:0] = stored 3-bit parity XOR recomputed parity.
- Correction map:
  - 000: no change
  - 111: flip d0; 011: flip d1; 101: flip d2; 110: flip d3
  - 001, 010, 100: flip parity bit 0, 1, 2 respectively
  - Every nonzero syndrome counts as a correction. Double errors are miscorrected; SEC only, no DED.
- IDLE:
  - On start=1: capture data_in and parity_in into working registers, clear corr_mask and the block index, go to CHECK.
  - start while busy is ignored and not queued.
- CHECK: one block per cycle, index 0 up to blocks-1.
  - Update the working nibble and its parity field in place.
  - Set corr_mask[i] if the syndrome is nonzero.
  - Increment err_count by 1 per corrected block, saturating at all-ones.
  - After index blocks-1, go to COMMIT.
- COMMIT (one cycle):
  - data_out and parity_out are driven from the working registers.
  - wr_en=1 only if corr_mask != 0.
  - done=1 always.
  - Next state is IDLE.
- Latency: start sampled at edge 0 gives done high in the cycle after edge blocks+1 (width=8: 3 cycles). The earliest next start is accepted in the cycle after done.
- err_clr has priority over a simultaneous increment. It is legal in any state and does not affect the FSM.
- data_out and parity_out hold their last values outside COMMIT.
- Reset mid-pass aborts immediately: no wr_en, no done, and the pass is not resumed.
- Inputs are sampled only at capture; later changes during the pass are ignored.

Decomposition:
- hamming_pkg holds:
  - state_t enum {IDLE, CHECK, COMMIT}
  - function hamming74_parity(4b) returning 3b
  - syndrome-to-flip-position constants
- One natural sub-module, hamming74_block_fix. It is combinational: 4b data + 3b parity in; corrected 4b data, corrected 3b parity and a corrected flag out. One instance is time-multiplexed over blocks by the FSM.

Test Plan:
- Clean word: data_in=8'hA5, parity_in=6'h2A, start -> done at +3 cycles, wr_en never high, corr_mask=00, err_count unchanged.
- Data single error: data_in=8'hA1 (d2 of block0 flipped), parity_in=6'h2A -> wr_en pulse with data_out=8'hA5, parity_out=6'h2A, corr_mask=01, err_count +1.
- Parity single error: data_in=8'hA5, parity_in=6'h3A -> data_out=8'hA5, parity_out=6'h2A, corr_mask=10, wr_en=1.
- Errors in both blocks: data_in=8'hB4 -> data_out=8'hA5, corr_mask=11, err_count +2. Then repeat from err_count=8'hFF: err_count stays 8'hFF.
- start held high during CHECK, and err_clr asserted in the same cycle as a correction -> only one pass and one done pulse; err_count=0 after that cycle.
- rst_n low during CHECK -> all outputs 0 asynchronously, no done; the next start runs a full pass normally.
